// File: rtl/serial_addsub_pkg.sv
// Shared types and helpers for the digit-serial adder/subtractor.
package serial_addsub_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Counter width for CC digits; never narrower than one bit.
    function automatic int calc_cw(input int cc);
        return (cc > 1) ? $clog2(cc) : 1;
    endfunction

endpackage

// File: rtl/serial_add_digit.sv
// Combinational DW-bit ripple slice. It uses one AND per bit, which keeps it cheap
// in garbled circuits: cout = c ^ ((a^c) & (b^c)).
module serial_add_digit #(
    parameter int DW = 2
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic          inv,
    input  logic          cin,
    output logic [DW-1:0] s,
    output logic          cn,
    output logic          c_msb_in
);

    always_comb begin
        logic cy;
        logic bx;
        cy       = cin;
        bx       = 1'b0;
        s        = '0;
        c_msb_in = 1'b0;
        for (int i = 0; i < DW; i++) begin
            bx = b[i] ^ inv;
            if (i == DW - 1) c_msb_in = cy;
            s[i] = a[i] ^ bx ^ cy;
            cy   = cy ^ ((a[i] ^ cy) & (bx ^ cy));
        end
        cn = cy;
    end

endmodule

// File: rtl/serial_addsub_seq.sv
// Digit-serial N-bit add/sub (N = DW*CC), LSB digit first, one digit per cycle.
// Define SERIAL_ADDSUB_SUB_EN to honour the sub input; otherwise the block is add-only.
module serial_addsub_seq
    import serial_addsub_pkg::*;
#(
    parameter int DW = 2,
    parameter int CC = 512
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          sub,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] c,
    output logic          c_valid,
    output logic          busy,
    output logic          done,
    output logic          cout,
    output logic          ovf
);

    localparam int CW = calc_cw(CC);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          carry;
    logic          sub_eff;
    logic          m;
    logic          accept;
    logic          take;
    logic          last;
    logic          cin;
    logic [DW-1:0] sum;
    logic          cn;
    logic          c_msb;

    assign accept = (state == ST_IDLE) && start;
    assign take   = accept || (state == ST_RUN);
    assign last   = ((state == ST_RUN) && (cnt == CW'(CC - 1))) || (accept && (CC == 1));
    assign cin    = (state == ST_IDLE) ? sub_eff : carry;
    assign busy   = (state == ST_RUN);

`ifdef SERIAL_ADDSUB_SUB_EN
    logic mode;
    assign sub_eff = sub;
    assign m       = (state == ST_IDLE) ? sub : mode;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        mode <= 1'b0;
        else if (accept) mode <= sub;
    end
`else
    logic unused_sub;
    assign unused_sub = sub;
    assign sub_eff    = 1'b0;
    assign m          = 1'b0;
`endif

    serial_add_digit #(.DW(DW)) u_digit (
        .a        (a),
        .b        (b),
        .inv      (m),
        .cin      (cin),
        .s        (sum),
        .cn       (cn),
        .c_msb_in (c_msb)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            carry   <= 1'b0;
            c       <= '0;
            c_valid <= 1'b0;
            done    <= 1'b0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            c_valid <= take;
            done    <= take && last;
            if (take) begin
                c     <= sum;
                carry <= cn;
            end
            // Flags clear on a new op; the last-digit update below wins for CC==1.
            if (accept) begin
                cout <= 1'b0;
                ovf  <= 1'b0;
            end
            if (take && last) begin
                cout  <= cn;
                ovf   <= c_msb ^ cn;
                cnt   <= '0;
                state <= ST_IDLE;
            end else if (take) begin
                cnt   <= cnt + 1'b1;
                state <= ST_RUN;
            end
        end
    end

endmodule
